// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: shared defaults, saturation constants and stage payload for pipelined_addsub
package pipelined_addsub_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 4;
  typedef struct packed {
    logic valid;
    logic sub;
    logic sat;
    logic amsb;
    logic bmsb;
  } stage_t;
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: SW-bit adder slice with registered sum and carry, hold enable
module addsub_slice
  import pipelined_addsub_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {co, s} <= '0;
    else if (en) {co, s} <= {1'b0, a} + {1'b0, b} + (SW + 1)'(ci);
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: sliced, pipelined add/subtract with optional signed saturation and valid/ready flow
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int SW = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
  logic adv;
  logic c0;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] raw;
  stage_t pl [STAGES];
  stage_t p;
  assign adv = out_ready || !out_valid;
  assign in_ready = adv;
  assign b_eff = sub ? ~b : b;
  assign c0 = sub ? ~cin : cin;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) pl[k] <= '0;
    end else if (adv) begin
      pl[0] <= '{valid: in_valid, sub: sub, sat: sat, amsb: a[WIDTH-1], bmsb: b_eff[WIDTH-1]};
      for (int k = 1; k < STAGES; k++) pl[k] <= pl[k-1];
    end
  // oa/ob hold the operand slices not yet consumed; acc grows by one finished slice per stage
  for (genvar k = 0; k < STAGES; k++) begin : g
    logic [WIDTH-k*SW-1:0] oa, ob;
    logic [(k+1)*SW-1:0] acc;
    logic [SW-1:0] s;
    logic ci, co;
    if (k == 0) begin : h
      assign oa = a;
      assign ob = b_eff;
      assign ci = c0;
      assign acc = s;
    end else begin : h
      logic [k*SW-1:0] lo;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          oa <= '0;
          ob <= '0;
          lo <= '0;
        end else if (adv) begin
          oa <= g[k-1].oa[WIDTH-(k-1)*SW-1:SW];
          ob <= g[k-1].ob[WIDTH-(k-1)*SW-1:SW];
          lo <= g[k-1].acc;
        end
      assign ci = g[k-1].co;
      assign acc = {s, lo};
    end
    addsub_slice #(.SW(SW)) u_slice (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (adv),
      .a    (oa[SW-1:0]),
      .b    (ob[SW-1:0]),
      .ci   (ci),
      .s    (s),
      .co   (co)
    );
  end
  assign p = pl[STAGES-1];
  assign raw = g[STAGES-1].acc;
  assign out_valid = p.valid;
  assign cout = g[STAGES-1].co;
  assign overflow = (p.amsb == p.bmsb) && (raw[WIDTH-1] != p.amsb);
  assign sum = (SAT_EN != 0 && p.sat && overflow) ? (p.amsb ? SMIN : SMAX) : raw;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for pipelined_addsub (32-bit, 4 stages, saturation on)
module tb_pipelined_addsub;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, sat = 0, out_ready = 1;
  logic in_ready, out_valid, cout, overflow;
  logic [31:0] a = 0, b = 0, sum;
  int cyc = 0, total = 0, passes = 0;
  typedef struct {
    logic [31:0] s;
    logic c, o;
    int acc;
    bit lat;
  } exp_t;
  typedef struct {
    logic [31:0] a, b;
    logic ci, sb, st;
    logic [31:0] s;
    logic c, o;
  } vec_t;
  exp_t q[$];
  exp_t e;
  vec_t iso[7] = '{
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
    '{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1},
    '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1},
    '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 1'b0, 32'h00000006, 1'b1, 1'b0}
  };
  vec_t bp[8] = '{
    '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0},
    '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0},
    '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0},
    '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1},
    '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{32'h00000100, 32'h00000200, 1'b0, 1'b0, 1'b0, 32'h00000300, 1'b0, 1'b0},
    '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1}
  };
  vec_t post = '{32'h00000002, 32'h00000003, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};

  pipelined_addsub #(.WIDTH(32), .STAGES(4), .SAT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h", n, got, want);
  endfunction

  task automatic send(input vec_t v, input bit push, input bit lat);
    int n = 0;
    in_valid = 1; a = v.a; b = v.b; cin = v.ci; sub = v.sb; sat = v.st;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 50) begin
        check("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    if (push) q.push_back('{v.s, v.c, v.o, cyc, lat});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic stall_d = 0;
  logic [31:0] sum_d;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_d && out_valid) check("stall_sum_stable", sum, sum_d);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_out: got sum %h with no result expected", sum);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.s);
          check("cout", 32'(cout), 32'(e.c));
          check("overflow", 32'(overflow), 32'(e.o));
          if (e.lat) check("latency", 32'(cyc - e.acc), 32'd4);
        end
      end
      stall_d = out_valid && !out_ready;
      sum_d = sum;
    end else stall_d = 0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    foreach (iso[i]) begin
      send(iso[i], 1, 1);
      in_valid = 0;
      drain();
    end
    fork
      begin
        foreach (bp[i]) send(bp[i], 1, 0);
        in_valid = 0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) begin
          @(negedge clk);
          check("in_ready_stall", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    for (int i = 0; i < 3; i++) send(iso[i], 0, 0);
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_sum", sum, 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2 rst_n = 1;
    repeat (8) @(posedge clk);
    #1;
    send(post, 1, 1);
    in_valid = 0;
    drain();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined signed/unsigned adder/subtractor; next generation of the team's 16-bit ripple adder.
- Splits the WIDTH-bit operation into STAGES equal slices, one slice per pipeline stage, with the carry registered between stages.
- Adds a subtract mode, optional signed saturation and a valid/ready streaming handshake.
- Sits in datapath/ALU pipelines where a full-width ripple chain misses timing.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES; >= 2.
- STAGES, 4, pipeline depth and slice count; slice width SW = WIDTH/STAGES; >= 1.
- SAT_EN, 1, 1 = saturation logic present; 0 = the sat input is ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts the input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = a+b+cin; 1 = a-b-cin.
- sat  in  1  1 = clamp the result on signed overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  add: carry-out; sub: NOT borrow (1 = no borrow).
- overflow  out  1  signed (two's complement) overflow of the unsaturated result.

Behaviour:
- Reset (asynchronous, rst_n=0): all stage valid bits = 0.
  - Outputs: out_valid=0, sum=0, cout=0, overflow=0; in_ready=1 once rst_n=1.
  - Data registers also clear to 0.
- Operand conditioning at input:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - Datapath computes a + b_eff + c0.
- Stage k (0..STAGES-1):
  - Adds slice k of a and b_eff plus the carry from stage k-1 (c0 for k=0).
  - Registers the slice sum and carry-out.
  - Forwards the not-yet-added upper slices of a and b_eff unchanged (delay triangle).
  - Forwards the completed lower sum slices unchanged.
  - Carries the per-transaction sub/sat flags and the MSBs a[W-1], b_eff[W-1].
- Last stage outputs:
  - cout = final carry.
  - overflow = (a[W-1]==b_eff[W-1]) && (raw_sum[W-1]!=a[W-1]).
  - If SAT_EN && sat && overflow: sum = a[W-1] ? {1'b1,{W-1{0}}} : {1'b0,{W-1{1}}}. Otherwise sum = raw sum.
  - overflow reports the raw condition even when saturated; cout is never modified by saturation.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid, with no backpressure.
- Throughput: one transaction per cycle.
- Flow control (global stall):
  - adv = out_ready || !out_valid.
  - in_ready = adv (combinational).
  - When adv=1, all stages shift; a bubble is inserted when in_valid=0.
  - When adv=0, all stage registers hold.
  - Output fields (sum, cout, overflow) are stable while out_valid && !out_ready.
- Output handshake: a result transfers on out_valid && out_ready.
  - Full pipeline with out_ready=1: simultaneous accept and retire in the same cycle, no bubble.
- Bubbles: valid=0 stages may hold stale data; only the valid bits matter.
- No combinational path from in_valid or a/b to any output.
- in_ready depends only on out_ready and out_valid.
- STAGES=1: single registered adder, latency 1.

Decomposition:
- Shared package pipelined_addsub_pkg:
  - default WIDTH/STAGES constants;
  - functions sat_max(width) and sat_min(width);
  - the stage-payload struct typedef (valid, sub, sat, msb flags).
- One sub-module: addsub_slice.
  - SW-bit adder plus pipeline register stage, with hold enable and asynchronous active-low reset.
  - Generated STAGES times.

Test Plan (WIDTH=32, STAGES=4, SAT_EN=1):
- Unsigned wrap: a=FFFFFFFF, b=00000001, cin=0, sub=0 -> sum=00000000, cout=1, overflow=0; out_valid exactly 4 cycles after accept.
- Carry across slices: a=00FFFFFF, b=0, cin=1 -> sum=01000000, cout=0, overflow=0.
- Signed overflow and saturation: a=7FFFFFFF, b=1, sat=0 -> sum=80000000, overflow=1. Same operands with sat=1 -> sum=7FFFFFFF, overflow=1.
- Subtract: a=5, b=7, sub=1, cin=0 -> sum=FFFFFFFE, cout=0, overflow=0. Then a=80000000, b=1, sub=1, sat=1 -> sum=80000000, overflow=1, cout=1.
- Backpressure: 8 back-to-back inputs, out_ready=0 for 3 cycles mid-stream -> in_ready=0 for those 3 cycles; 8 results in order, none lost or duplicated; sum stable while stalled.
- Reset mid-flight: rst_n low for 1 cycle with 3 transactions in flight -> out_valid=0 immediately (asynchronous); no result emerges after release; the next input appears 4 cycles after acceptance.
